dynamic_rca: RTL and testbench



---
 rtl/dynamic_rca.sv | 87 ++++++++
 tb/tb_dynamic_rca.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dynamic_rca.sv
// dynamic_rca
//   N-bit ripple-carry adder with a clocked result-hold stage.
//   With enable high, the outputs follow the inputs combinationally through
//   the full-adder chain. With enable low, the outputs show the result that
//   was captured at the last enabled rising edge.
//
// Ports
//   clk     in   1  clock; the hold register captures on the rising edge
//   rst     in   1  asynchronous, active-high reset (clears the hold register only)
//   enable  in   1  1 = live result, 0 = held result
//   A, B    in   N  unsigned operands
//   Cin     in   1  carry-in
//   Cout    out  1  carry-out of bit N-1
//   P       out  N  propagate vector, A ^ B
//   S       out  N  sum bits
module dynamic_rca #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         Cout,
  output logic [N-1:0] P,
  output logic [N-1:0] S
);

  logic [N:0]   c_live;
  logic [N-1:0] p_live;
  logic [N-1:0] s_live;

  logic         cout_q, cout_d;
  logic [N-1:0] s_q, s_d;
  logic [N-1:0] p_q, p_d;

  // Strict ripple: each bit's carry-in is the previous bit's carry-out.
  // The per-bit XOR feeds both the sum and the propagate output.
  always_comb begin
    c_live    = '0;
    p_live    = '0;
    s_live    = '0;
    c_live[0] = Cin;
    for (int i = 0; i < N; i++) begin
      p_live[i]   = A[i] ^ B[i];
      s_live[i]   = p_live[i] ^ c_live[i];
      c_live[i+1] = (A[i] & B[i]) | (p_live[i] & c_live[i]);
    end
  end

  always_comb begin
    cout_d = cout_q;
    s_d    = s_q;
    p_d    = p_q;
    if (enable) begin
      cout_d = c_live[N];
      s_d    = s_live;
      p_d    = p_live;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cout_q <= 1'b0;
      s_q    <= '0;
      p_q    <= '0;
    end else begin
      cout_q <= cout_d;
      s_q    <= s_d;
      p_q    <= p_d;
    end
  end

  // Reset does not gate the live path: with enable high the sum stays visible.
  always_comb begin
    Cout = cout_q;
    S    = s_q;
    P    = p_q;
    if (enable) begin
      Cout = c_live[N];
      S    = s_live;
      P    = p_live;
    end
  end

endmodule

// File: tb/tb_dynamic_rca.sv
module tb_dynamic_rca;
  localparam int N = 16;
  localparam int W = 2 * N + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         Cout;
  logic [N-1:0] P;
  logic [N-1:0] S;

  int errors = 0;
  int checks = 0;

  // Full period of 2N+2 time units.
  always #(N + 1) clk = ~clk;

  dynamic_rca #(.N(N)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .A(A), .B(B), .Cin(Cin),
    .Cout(Cout), .P(P), .S(S)
  );

  // Reference: plain integer addition and XOR, plus the value last captured.
  function automatic logic [W-1:0] ref_live(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic ci);
    logic [N:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    return {sum, a ^ b};
  endfunction

  logic [W-1:0] held_m = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) held_m <= '0;
    else if (enable) held_m <= ref_live(A, B, Cin);
  end

  function automatic logic [W-1:0] expected();
    return enable ? ref_live(A, B, Cin) : held_m;
  endfunction

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                       input logic en);
    A = a; B = b; Cin = ci; enable = en;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({Cout, S, P} !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", {Cout, S, P}, {W{1'b0}});
    end
    drive(16'h8001, 16'h8001, 1'b1, 1'b1);
    #1;
    checks++;
    if ({Cout, S, P} !== {1'b1, 16'h0003, 16'h0000}) begin
      errors++;
      $display("FAIL reset_live got=%h exp=%h", {Cout, S, P}, {1'b1, 16'h0003, 16'h0000});
    end
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if ({Cout, S, P} !== '0) begin
      errors++;
      $display("FAIL reset_no_capture got=%h exp=%h", {Cout, S, P}, {W{1'b0}});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] vec [5];
    logic [W-1:0] exp [5];
    vec[0] = {1'b1, 16'hFFFF, 16'h0000}; exp[0] = {1'b1, 16'h0000, 16'hFFFF};
    vec[1] = {1'b0, 16'h1234, 16'h4321}; exp[1] = {1'b0, 16'h5555, 16'h5115};
    vec[2] = {1'b1, 16'hFFFF, 16'hFFFF}; exp[2] = {1'b1, 16'hFFFF, 16'h0000};
    vec[3] = {1'b0, 16'h0000, 16'h0000}; exp[3] = {1'b0, 16'h0000, 16'h0000};
    vec[4] = {1'b0, 16'h8000, 16'h8000}; exp[4] = {1'b1, 16'h0000, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(vec[i][2*N-1:N], vec[i][N-1:0], vec[i][W-1], 1'b1);
      #1;
      checks++;
      if ({Cout, S, P} !== exp[i]) begin
        errors++;
        $display("FAIL directed_%0d got=%h exp=%h", i, {Cout, S, P}, exp[i]);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    drive(16'h00FF, 16'h0001, 1'b0, 1'b1);
    @(negedge clk);
    drive(16'h0000, 16'h0000, 1'b1, 1'b0);
    #1;
    checks++;
    if ({Cout, S, P} !== {1'b0, 16'h0100, 16'h00FE}) begin
      errors++;
      $display("FAIL hold got=%h exp=%h", {Cout, S, P}, {1'b0, 16'h0100, 16'h00FE});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({Cout, S, P} !== {1'b0, 16'h0100, 16'h00FE}) begin
      errors++;
      $display("FAIL hold_keep got=%h exp=%h", {Cout, S, P}, {1'b0, 16'h0100, 16'h00FE});
    end
  endtask

  // Inputs change while enabled but with no edge in between: falling enable
  // must expose the earlier captured value, not the current live one.
  task automatic test_enable_fall();
    @(negedge clk);
    drive(16'hA5A5, 16'h1111, 1'b1, 1'b1);
    @(negedge clk);
    drive(16'h0F0F, 16'h0101, 1'b0, 1'b1);
    #3;
    enable = 1'b0;
    #1;
    checks++;
    if ({Cout, S, P} !== {1'b0, 16'hB6B7, 16'hB4B4}) begin
      errors++;
      $display("FAIL enable_fall got=%h exp=%h", {Cout, S, P}, {1'b0, 16'hB6B7, 16'hB4B4});
    end
  endtask

  task automatic test_reset_midcycle();
    @(negedge clk);
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    @(negedge clk);
    enable = 1'b0;
    #1;
    checks++;
    if ({Cout, S, P} !== {1'b1, 16'hFFFF, 16'h0000}) begin
      errors++;
      $display("FAIL pre_reset got=%h exp=%h", {Cout, S, P}, {1'b1, 16'hFFFF, 16'h0000});
    end
    #4;
    rst = 1'b1;
    #1;
    checks++;
    if ({Cout, S, P} !== '0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", {Cout, S, P}, {W{1'b0}});
    end
    #2;
    rst = 1'b0;
    @(negedge clk);
    drive(16'h0003, 16'h0004, 1'b1, 1'b1);
    @(negedge clk);
    enable = 1'b0;
    #1;
    checks++;
    if ({Cout, S, P} !== {1'b0, 16'h0008, 16'h0007}) begin
      errors++;
      $display("FAIL recapture got=%h exp=%h", {Cout, S, P}, {1'b0, 16'h0008, 16'h0007});
    end
  endtask

  task automatic test_random_live();
    int bad;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      drive(N'($urandom), N'($urandom), 1'($urandom), 1'b1);
      @(posedge clk);
      #(N);
      checks++;
      if ({Cout, S, P} !== ref_live(A, B, Cin)) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_live_%0d A=%h B=%h Cin=%b got=%h exp=%h",
                   i, A, B, Cin, {Cout, S, P}, ref_live(A, B, Cin));
      end
    end
  endtask

  task automatic test_random_mixed();
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      drive(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
      #1;
      checks++;
      if ({Cout, S, P} !== expected()) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_mixed_%0d en=%b got=%h exp=%h",
                   i, enable, {Cout, S, P}, expected());
      end
    end
  endtask

  initial begin
    void'($urandom(32'h5eed_1234));
    rst = 1'b1;
    #5;
    rst = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_enable_fall();
    test_reset_midcycle();
    test_random_live();
    test_random_mixed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
